// File: rtl/sc_spi_slv.sv
// SPI target protocol engine.
// Oversamples CSB/SCLK/MOSI on SPICLK, exchanges DWIDTH+1 bit frames with a
// master and moves data through 32-bit word buffers addressed by TXDPT/RXDPT.
// Optional feature macro: SC_SPI_SLV_MISO_OE_EN adds the MISOOE output enable.
module sc_spi_slv (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic        ENABLE,
  input  logic [8:0]  DWIDTH,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        BORDER,
  input  logic [31:0] TXDATA,
  output logic [3:0]  TXDPT,
  output logic [31:0] RXDATA,
  output logic        RXVALID,
  output logic [3:0]  RXDPT,
  output logic        SPIBUSY,
  output logic        FRMDONE,
  output logic        FRMERR,
  input  logic        CSB,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO
`ifdef SC_SPI_SLV_MISO_OE_EN
  ,
  output logic        MISOOE
`endif
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  csb_q, sclk_q;
  logic [1:0]  mosi_q;
  // 10 bits so a full 512-bit frame can be told apart from 511 received bits
  logic [9:0]  k_q, k_d;
  logic [31:0] rx_word_q, rx_word_d;
  logic        miso_q, miso_d;
  logic        rxvalid_q, rxvalid_d;
  logic [31:0] rxdata_q, rxdata_d;
  logic [3:0]  rxdpt_q, rxdpt_d;
  logic        frmdone_q, frmdone_d;
  logic        frmerr_q, frmerr_d;

  logic       csb_fall, csb_rise, sclk_edge, lead, trail, mosi_s;
  logic       in_range, word_done;
  logic [8:0] ptr_k, pos;
  logic [3:0] cur_word;
  logic [4:0] cur_bit;
  logic [9:0] dw_p1, k_inc;
  logic       ev_enter, ev_abort, ev_end, ev_sample, ev_load;

  // Two-stage synchronisers plus a third stage for edge detection. CSB resets
  // low so a CSB already low when reset lifts never looks like a fresh fall.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      csb_q  <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      csb_q  <= {csb_q[1:0], CSB};
      sclk_q <= {sclk_q[1:0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign csb_fall  = csb_q[2] & ~csb_q[1];
  assign csb_rise  = ~csb_q[2] & csb_q[1];
  // Still accept an SCLK edge in the CSB-rise cycle so a late last bit counts.
  assign sclk_edge = (sclk_q[2] ^ sclk_q[1]) & (~csb_q[1] | ~csb_q[2]);
  assign lead      = sclk_edge & (sclk_q[1] != CPOL);
  assign trail     = sclk_edge & (sclk_q[1] == CPOL);
  assign mosi_s    = mosi_q[1];

  // Bit position in the word buffer for the current bit; past the frame end
  // the pointer stays on the last bit so TXDPT does not wander.
  assign in_range  = (k_q <= {1'b0, DWIDTH});
  assign ptr_k     = in_range ? k_q[8:0] : DWIDTH;
  assign pos       = BORDER ? {ptr_k[8:3], ~ptr_k[2:0]} : (DWIDTH - ptr_k);
  assign cur_word  = pos[8:5];
  assign cur_bit   = pos[4:0];
  assign word_done = BORDER ? ((k_q[4:0] == 5'd31) || (k_q[8:0] == DWIDTH))
                            : (pos[4:0] == 5'd0);
  assign dw_p1     = {1'b0, DWIDTH} + 10'd1;
  assign k_inc     = (k_q == 10'h3ff) ? k_q : k_q + 10'd1;

  assign ev_enter  = (state_q == StIdle) & csb_fall & ENABLE;
  assign ev_abort  = (state_q == StActive) & ~ENABLE;
  assign ev_end    = (state_q == StActive) & ENABLE & csb_rise;
  assign ev_sample = (state_q == StActive) & ENABLE & (CPHA ? trail : lead);
  assign ev_load   = (state_q == StActive) & ENABLE & (CPHA ? lead : trail);

  // State register.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: enter on CSB fall, leave on CSB rise or loss of ENABLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (csb_fall && ENABLE) state_d = StActive;
      StActive: if (!ENABLE || csb_rise) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath and pulse outputs; a sample in the CSB-rise cycle is applied
  // before the frame length is judged.
  always_comb begin
    k_d       = k_q;
    rx_word_d = rx_word_q;
    miso_d    = miso_q;
    rxvalid_d = 1'b0;
    rxdata_d  = rxdata_q;
    rxdpt_d   = rxdpt_q;
    frmdone_d = 1'b0;
    frmerr_d  = 1'b0;
    if (ev_enter) begin
      k_d       = '0;
      rx_word_d = '0;
      miso_d    = CPHA ? 1'b0 : TXDATA[cur_bit];
    end
    if (ev_sample) begin
      k_d = k_inc;
      if (in_range) begin
        rx_word_d[cur_bit] = mosi_s;
        if (word_done) begin
          rxvalid_d = 1'b1;
          rxdata_d  = rx_word_d;
          rxdpt_d   = cur_word;
          rx_word_d = '0;
        end
      end
    end
    if (ev_load) begin
      miso_d = in_range & TXDATA[cur_bit];
    end
    if (ev_end) begin
      frmdone_d = (k_d == dw_p1);
      frmerr_d  = (k_d != dw_p1);
      k_d       = '0;
      rx_word_d = '0;
      miso_d    = 1'b0;
    end
    if (ev_abort) begin
      frmerr_d  = 1'b1;
      k_d       = '0;
      rx_word_d = '0;
      miso_d    = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge SPICLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      k_q       <= '0;
      rx_word_q <= '0;
      miso_q    <= 1'b0;
      rxvalid_q <= 1'b0;
      rxdata_q  <= '0;
      rxdpt_q   <= '0;
      frmdone_q <= 1'b0;
      frmerr_q  <= 1'b0;
    end else begin
      k_q       <= k_d;
      rx_word_q <= rx_word_d;
      miso_q    <= miso_d;
      rxvalid_q <= rxvalid_d;
      rxdata_q  <= rxdata_d;
      rxdpt_q   <= rxdpt_d;
      frmdone_q <= frmdone_d;
      frmerr_q  <= frmerr_d;
    end
  end

  assign TXDPT   = cur_word;
  assign RXDATA  = rxdata_q;
  assign RXVALID = rxvalid_q;
  assign RXDPT   = rxdpt_q;
  assign SPIBUSY = (state_q == StActive);
  assign FRMDONE = frmdone_q;
  assign FRMERR  = frmerr_q;
  assign MISO    = miso_q;
`ifdef SC_SPI_SLV_MISO_OE_EN
  assign MISOOE  = (state_q == StActive);
`endif

endmodule

// File: tb/tb_sc_spi_slv.sv
// Self-checking bench for sc_spi_slv: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_sc_spi_slv;

  localparam int Half = 4;

  logic        SPICLK = 1'b0;
  logic        SYSRSTB, ENABLE, CPOL, CPHA, BORDER, CSB, SCLK, MOSI;
  logic [8:0]  DWIDTH;
  logic [31:0] TXDATA, RXDATA;
  logic [3:0]  TXDPT, RXDPT;
  logic        RXVALID, SPIBUSY, FRMDONE, FRMERR, MISO;
`ifdef SC_SPI_SLV_MISO_OE_EN
  logic        misooe;
`endif

  logic [31:0]  txmem [16];
  logic [511:0] frm;
  logic [63:0]  last_miso;
  int           n_checks = 0;
  int           n_fail = 0;

  logic [35:0] got_rx [$];
  logic [3:0]  txdpt_seq [$];
  int          n_done = 0;
  int          n_err = 0;
  logic        prev_busy = 1'b0;

  assign TXDATA = txmem[TXDPT];

  always #5 SPICLK = ~SPICLK;

  sc_spi_slv dut (
    .SPICLK  (SPICLK),
    .SYSRSTB (SYSRSTB),
    .ENABLE  (ENABLE),
    .DWIDTH  (DWIDTH),
    .CPOL    (CPOL),
    .CPHA    (CPHA),
    .BORDER  (BORDER),
    .TXDATA  (TXDATA),
    .TXDPT   (TXDPT),
    .RXDATA  (RXDATA),
    .RXVALID (RXVALID),
    .RXDPT   (RXDPT),
    .SPIBUSY (SPIBUSY),
    .FRMDONE (FRMDONE),
    .FRMERR  (FRMERR),
    .CSB     (CSB),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
`ifdef SC_SPI_SLV_MISO_OE_EN
    ,
    .MISOOE  (misooe)
`endif
  );

  // Record every pulse-cycle and the word pointers seen during each frame.
  always @(negedge SPICLK) begin
    if (RXVALID) got_rx.push_back({RXDPT, RXDATA});
    if (FRMDONE) n_done++;
    if (FRMERR) n_err++;
    if (SPIBUSY && (!prev_busy || txdpt_seq.size() == 0 || txdpt_seq[$] != TXDPT))
      txdpt_seq.push_back(TXDPT);
    prev_busy = SPIBUSY;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-buffer position of the k-th bit on the wire.
  function automatic int wpos(input int k);
    if (BORDER) return 8 * (k / 8) + 7 - (k % 8);
    return int'(DWIDTH) - k;
  endfunction

  function automatic logic [31:0] word_of(input int w);
    logic [31:0] v;
    for (int b = 0; b < 32; b++) v[b] = ((32 * w + b) <= int'(DWIDTH)) ? frm[32 * w + b] : 1'b0;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rxvalid"}, RXVALID, 0);
    check_eq({tag, "_frmdone"}, FRMDONE, 0);
    check_eq({tag, "_frmerr"}, FRMERR, 0);
    check_eq({tag, "_busy"}, SPIBUSY, 0);
    check_eq({tag, "_miso"}, MISO, 0);
    check_eq({tag, "_rxdata"}, RXDATA, 0);
    check_eq({tag, "_rxdpt"}, RXDPT, 0);
  endtask

  // One frame as the master sees it. cut_at >= 0 interrupts before that bit,
  // by reset (cut_rst) or by dropping ENABLE; clocking then carries on.
  task automatic run_frame(input int nsent, input int cut_at, input bit cut_rst);
    int dw, nb, miso_bad, r0, d0, e0, t0, top, last, nexp;
    logic b, e, got;
    logic [35:0] exp_rx [$];
    logic [3:0]  exp_seq [$];
    int p;
    dw = int'(DWIDTH);
    miso_bad = 0;
    last_miso = '0;
    r0 = got_rx.size();
    d0 = n_done;
    e0 = n_err;
    SCLK = CPOL;
    repeat (4) @(negedge SPICLK);
    t0 = txdpt_seq.size();
    CSB = 1'b0;
    repeat (6) @(negedge SPICLK);
    for (int k = 0; k < nsent; k++) begin
      if (k == cut_at) begin
        if (cut_rst) begin
          SYSRSTB = 1'b0;
          repeat (2) @(negedge SPICLK);
          check_idle_outputs("rst_mid");
          check_eq("rst_mid_txdpt", TXDPT, 0);
          SYSRSTB = 1'b1;
        end else begin
          ENABLE = 1'b0;
          repeat (2) @(negedge SPICLK);
        end
      end
      if (k <= dw) b = frm[wpos(k)];
      else b = 1'($urandom);
      e = 1'b0;
      if (k <= dw && (cut_at < 0 || k < cut_at)) begin
        p = wpos(k);
        e = txmem[p / 32][p % 32];
      end
      if (!CPHA) begin
        MOSI = b;
        repeat (Half) @(negedge SPICLK);
        got = MISO;
        SCLK = ~CPOL;
        repeat (Half) @(negedge SPICLK);
        SCLK = CPOL;
      end else begin
        SCLK = ~CPOL;
        MOSI = b;
        repeat (Half) @(negedge SPICLK);
        got = MISO;
        SCLK = CPOL;
        repeat (Half) @(negedge SPICLK);
      end
      if (got !== e) miso_bad++;
      last_miso = {last_miso[62:0], got};
      if (k == 1 && cut_at < 0) check_eq("busy_mid", SPIBUSY, 1);
    end
    repeat (Half) @(negedge SPICLK);
    CSB = 1'b1;
    repeat (8) @(negedge SPICLK);
    ENABLE = 1'b1;
    repeat (2) @(negedge SPICLK);

    // Reference model at frame level.
    nb = (cut_at >= 0) ? cut_at : nsent;
    top = dw / 32;
    if (!cut_rst) begin
      if (!BORDER) begin
        for (int w = top; w >= 0; w--)
          if (dw - 32 * w < nb) exp_rx.push_back({4'(w), word_of(w)});
      end else begin
        for (int w = 0; w <= top; w++) begin
          last = (32 * w + 31 < dw) ? 32 * w + 31 : dw;
          if (last < nb) exp_rx.push_back({4'(w), word_of(w)});
        end
      end
    end
    nexp = exp_rx.size();
    check_eq("rx_count", got_rx.size() - r0, nexp);
    for (int i = 0; i < nexp && (r0 + i) < got_rx.size(); i++)
      check_eq("rx_word", got_rx[r0 + i], exp_rx[i]);
    check_eq("frmdone", n_done - d0, (!cut_rst && cut_at < 0 && nb == dw + 1) ? 1 : 0);
    check_eq("frmerr", n_err - e0, (cut_rst || (cut_at < 0 && nb == dw + 1)) ? 0 : 1);
    check_eq("miso_bits_bad", miso_bad, 0);
    check_eq("busy_end", SPIBUSY, 0);
    if (cut_at < 0 && nsent >= dw + 1) begin
      for (int k = 0; k <= dw; k++)
        if (exp_seq.size() == 0 || exp_seq[$] != 4'(wpos(k) / 32)) exp_seq.push_back(4'(wpos(k) / 32));
      check_eq("txdpt_len", txdpt_seq.size() - t0, exp_seq.size());
      for (int i = 0; i < exp_seq.size() && (t0 + i) < txdpt_seq.size(); i++)
        check_eq("txdpt_seq", txdpt_seq[t0 + i], exp_seq[i]);
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic bo, input int dw);
    CPOL = pol;
    CPHA = pha;
    BORDER = bo;
    DWIDTH = 9'(dw);
  endtask

  initial begin
    int dw, m, r, ns;
    SYSRSTB = 1'b0;
    ENABLE = 1'b1;
    CSB = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    frm = '0;
    for (int i = 0; i < 16; i++) txmem[i] = '0;
    set_mode(0, 0, 0, 31);
    repeat (3) @(negedge SPICLK);
    check_idle_outputs("reset");
    check_eq("reset_txdpt", TXDPT, 0);
    SYSRSTB = 1'b1;
    repeat (4) @(negedge SPICLK);

    // Mode 0, single word.
    txmem[0] = 32'hA5C30F96;
    frm = '0;
    frm[31:0] = 32'h12345678;
    run_frame(32, -1, 0);
    check_eq("t1_rxdata", RXDATA, 32'h12345678);
    check_eq("t1_miso", last_miso[31:0], 32'hA5C30F96);

    // Mode 3, two words, high word first.
    set_mode(1, 1, 0, 63);
    frm = '0;
    frm[63:0] = 64'hDEADBEEF_01234567;
    run_frame(64, -1, 0);
    check_eq("t2_rxdata", RXDATA, 32'h01234567);
    check_eq("t2_rxdpt", RXDPT, 0);

    // Mode 1, byte order, two bytes.
    set_mode(0, 1, 1, 15);
    frm = '0;
    frm[15:0] = 16'h1234;
    run_frame(16, -1, 0);
    check_eq("t3_rxdata", RXDATA, 32'h00001234);

    // Short frame then full frame.
    set_mode(0, 0, 0, 31);
    frm = '0;
    frm[31:0] = 32'hCAFEF00D;
    run_frame(10, -1, 0);
    run_frame(32, -1, 0);

    // Overrun by four bits.
    frm[31:0] = 32'h0F1E2D3C;
    run_frame(36, -1, 0);
    check_eq("t5_tail_miso", last_miso[3:0], 0);

    // Reset mid-frame, then a clean frame.
    frm[31:0] = 32'h89ABCDEF;
    run_frame(32, 17, 1);
    run_frame(32, -1, 0);

    // ENABLE dropped mid-frame.
    run_frame(32, 5, 0);

    // Randomized frames.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 16; i++) txmem[i] = $urandom;
      for (int i = 0; i < 16; i++) frm[32 * i +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        m = $urandom_range(1, 16);
        dw = 8 * m - 1;
        set_mode(1'($urandom), 1'($urandom), 1, dw);
      end else begin
        dw = $urandom_range(0, 127);
        set_mode(1'($urandom), 1'($urandom), 0, dw);
      end
      r = $urandom_range(0, 5);
      if (r == 0 && dw >= 1) ns = $urandom_range(1, dw);
      else if (r == 1) ns = dw + 1 + $urandom_range(1, 4);
      else ns = dw + 1;
      run_frame(ns, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
